// File: rtl/mem_stage_mo_pkg.sv
// Shared definitions for the multi-outstanding MEM stage: one-hot load-op bit positions.
package mem_stage_mo_pkg;

   localparam int LOAD_OP_LEN = 5;

   localparam int LD_B  = 0;
   localparam int LD_H  = 1;
   localparam int LD_W  = 2;
   localparam int LD_BU = 3;
   localparam int LD_HU = 4;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data alignment: shift the response word by the byte offset,
// then sign- or zero-extend according to the one-hot load op.
module mem_load_align
   import mem_stage_mo_pkg::*;
(
   input  logic [31:0]            rdata_i,
   input  logic [1:0]             addr_lo_i,
   input  logic [LOAD_OP_LEN-1:0] load_op_i,
   output logic [31:0]            result_o
);

   logic [31:0] sh;

   assign sh = rdata_i >> {addr_lo_i, 3'b000};

   always_comb begin
      result_o = sh;
      if (load_op_i[LD_B]) begin
         result_o = {{24{sh[7]}}, sh[7:0]};
      end else if (load_op_i[LD_BU]) begin
         result_o = {24'h0, sh[7:0]};
      end else if (load_op_i[LD_H]) begin
         result_o = {{16{sh[15]}}, sh[15:0]};
      end else if (load_op_i[LD_HU]) begin
         result_o = {16'h0, sh[15:0]};
      end else if (load_op_i[LD_W]) begin
         result_o = sh;
      end
   end

endmodule

// File: rtl/mem_stage_mo.sv
// MEM stage with an in-order queue of up to DEPTH instructions, in-order memory
// responses matched to waiting entries, and silent discard of responses owed after flush.
module mem_stage_mo
   import mem_stage_mo_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 64
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   in_req_sent_i,
   input  logic                   in_is_load_i,
   input  logic [LOAD_OP_LEN-1:0] in_load_op_i,
   input  logic [1:0]             in_addr_lo_i,
   input  logic [DATA_W-1:0]      in_result_i,
   input  logic [PAYLOAD_W-1:0]   in_payload_i,
   input  logic                   data_ok_i,
   input  logic [DATA_W-1:0]      rdata_i,
   input  logic                   flush_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [DATA_W-1:0]      out_result_o,
   output logic [PAYLOAD_W-1:0]   out_payload_o,
   output logic [$clog2(DEPTH):0] owed_cnt_o,
   output logic                   busy_o
);

   localparam int PTR_W = $clog2(DEPTH);
   typedef logic [PTR_W:0] ptr_t;
   localparam ptr_t ONE = ptr_t'(1);

   if (DATA_W != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
      $error("mem_stage_mo: DATA_W must be 32 and DEPTH a power of 2 >= 2");
   end

   ptr_t head_q, head_d, tail_q, tail_d, rp_q, rp_d;
   ptr_t owed_q, owed_d, disc_q, disc_d;
   logic [DEPTH-1:0] wait_q, wait_d;

   logic [DATA_W-1:0]      result_q  [DEPTH];
   logic [PAYLOAD_W-1:0]   payload_q [DEPTH];
   logic [LOAD_OP_LEN-1:0] load_op_q [DEPTH];
   logic [1:0]             addr_lo_q [DEPTH];
   logic [DEPTH-1:0]       is_load_q;

   logic [PTR_W-1:0] head_idx, tail_idx, rp_idx;
   logic full, empty, enq, deq, enq_req;
   logic rsp_ok, rsp_live, rsp_drop;
   logic [31:0] aligned;

   assign head_idx = head_q[PTR_W-1:0];
   assign tail_idx = tail_q[PTR_W-1:0];
   assign rp_idx   = rp_q[PTR_W-1:0];

   assign empty = (head_q == tail_q);
   assign full  = (head_idx == tail_idx) && (head_q[PTR_W] != tail_q[PTR_W]);

   // The owed counter shares the port width; hold off new work once it saturates so
   // repeated flushes with many discards pending can never wrap it.
   assign in_ready_o    = !full && !(&owed_q);
   assign out_valid_o   = !empty && !wait_q[head_idx];
   assign out_result_o  = result_q[head_idx];
   assign out_payload_o = payload_q[head_idx];
   assign owed_cnt_o    = owed_q;
   assign busy_o        = !empty || (owed_q != '0);

   assign enq      = in_valid_i && in_ready_o && !flush_i;
   assign enq_req  = enq && in_req_sent_i;
   assign deq      = out_valid_o && out_ready_i && !flush_i;
   assign rsp_ok   = data_ok_i && (owed_q != '0);
   assign rsp_drop = rsp_ok && (disc_q != '0);
   assign rsp_live = rsp_ok && (disc_q == '0);

   mem_load_align u_align (
      .rdata_i   (rdata_i),
      .addr_lo_i (addr_lo_q[rp_idx]),
      .load_op_i (load_op_q[rp_idx]),
      .result_o  (aligned)
   );

   always_comb begin : next_state
      ptr_t idx;
      ptr_t span;
      logic found;
      head_d = head_q;
      tail_d = tail_q;
      wait_d = wait_q;
      owed_d = owed_q;
      disc_d = disc_q;
      if (rsp_live) wait_d[rp_idx] = 1'b0;
      if (enq) begin
         wait_d[tail_idx] = in_req_sent_i;
         tail_d           = tail_q + ONE;
      end
      if (deq) head_d = head_q + ONE;
      if (enq_req && !rsp_ok) begin
         owed_d = owed_q + ONE;
      end else if (rsp_ok && !enq_req) begin
         owed_d = owed_q - ONE;
      end
      if (rsp_drop) disc_d = disc_q - ONE;

      // rp tracks the oldest still-waiting entry, or the tail when none is waiting.
      rp_d  = tail_d;
      found = 1'b0;
      span  = tail_d - rp_q;
      idx   = rp_q;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rp_q + ptr_t'(k);
         if (!found && (ptr_t'(k) < span) && wait_d[idx[PTR_W-1:0]]) begin
            rp_d  = idx;
            found = 1'b1;
         end
      end

      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         rp_d   = '0;
         wait_d = '0;
         disc_d = owed_q - ptr_t'(rsp_ok);
         owed_d = owed_q - ptr_t'(rsp_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head_q <= '0;
         tail_q <= '0;
         rp_q   <= '0;
         owed_q <= '0;
         disc_q <= '0;
         wait_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         rp_q   <= rp_d;
         owed_q <= owed_d;
         disc_q <= disc_d;
         wait_q <= wait_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         result_q[tail_idx]  <= in_result_i;
         payload_q[tail_idx] <= in_payload_i;
         load_op_q[tail_idx] <= in_load_op_i;
         addr_lo_q[tail_idx] <= in_addr_lo_i;
         is_load_q[tail_idx] <= in_is_load_i;
      end
      if (rsp_live && is_load_q[rp_idx]) begin
         result_q[rp_idx] <= aligned;
      end
   end

   a_no_stray_rsp: assert property (@(posedge clk) disable iff (!resetn)
      !(data_ok_i && (owed_q == '0)));

endmodule
